// File: rtl/div_normalize_sequencer.sv
// div_normalize_sequencer: divider front end sharing one clz32 across operands; DIV_NORMALIZE_SIGNED_EN adds signed magnitudes
module div_normalize_clz (
    input  logic [31:0] a,
    output logic [4:0]  count
);
    always_comb begin
        count = 5'd31;
        for (int i = 0; i < 32; i++) if (a[i]) count = 5'(31 - i);
    end
endmodule

module div_normalize_sequencer #(
    parameter int ID_WIDTH  = 4,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_dividend,
    input  logic [31:0]         req_divisor,
    input  logic [ID_WIDTH-1:0] req_id,
`ifdef DIV_NORMALIZE_SIGNED_EN
    input  logic                req_signed,
    output logic                rsp_dividend_neg,
    output logic                rsp_divisor_neg,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ack,
    output logic [ID_WIDTH-1:0] rsp_id,
    output logic [4:0]          rsp_dividend_clz,
    output logic [4:0]          rsp_divisor_clz,
    output logic [31:0]         rsp_divisor_norm,
    output logic [5:0]          rsp_iterations,
    output logic                rsp_divisor_zero,
    output logic                rsp_quotient_zero
);
    typedef enum logic [1:0] {IDLE, CLZ_DIVIDEND, CLZ_DIVISOR, DONE} state_t;
    state_t      state;
    logic [31:0] dividend_r, divisor_r, clz_in, accept_dividend, accept_divisor;
    logic [4:0]  clz_out;
    logic        dividend_zero, divisor_zero, clz_gt;
`ifdef DIV_NORMALIZE_SIGNED_EN
    logic dividend_neg, divisor_neg;
    always_comb begin
        dividend_neg    = req_signed & req_dividend[31];
        divisor_neg     = req_signed & req_divisor[31];
        accept_dividend = dividend_neg ? -req_dividend : req_dividend;
        accept_divisor  = divisor_neg ? -req_divisor : req_divisor;
    end
`else
    always_comb begin
        accept_dividend = req_dividend;
        accept_divisor  = req_divisor;
    end
`endif
    always_comb begin
        clz_in       = state == CLZ_DIVISOR ? divisor_r : dividend_r;
        divisor_zero = ~|divisor_r;
        // a negative clz difference also means no quotient bits, whether or not it is flagged
        clz_gt       = dividend_zero | (rsp_dividend_clz > clz_out);
    end
    div_normalize_clz u_clz (.a(clz_in), .count(clz_out));
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            req_ready         <= 1'b1;
            rsp_valid         <= 1'b0;
            dividend_r        <= '0;
            divisor_r         <= '0;
            dividend_zero     <= 1'b0;
            rsp_id            <= '0;
            rsp_dividend_clz  <= '0;
            rsp_divisor_clz   <= '0;
            rsp_divisor_norm  <= '0;
            rsp_iterations    <= '0;
            rsp_divisor_zero  <= 1'b0;
            rsp_quotient_zero <= 1'b0;
`ifdef DIV_NORMALIZE_SIGNED_EN
            rsp_dividend_neg  <= 1'b0;
            rsp_divisor_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    dividend_r <= accept_dividend;
                    divisor_r  <= accept_divisor;
                    rsp_id     <= req_id;
`ifdef DIV_NORMALIZE_SIGNED_EN
                    rsp_dividend_neg <= dividend_neg;
                    rsp_divisor_neg  <= divisor_neg;
`endif
                    req_ready  <= 1'b0;
                    state      <= CLZ_DIVIDEND;
                end
                CLZ_DIVIDEND: begin
                    rsp_dividend_clz <= clz_out;
                    dividend_zero    <= ~|dividend_r;
                    state            <= CLZ_DIVISOR;
                end
                CLZ_DIVISOR: begin
                    rsp_divisor_clz   <= clz_out;
                    rsp_divisor_zero  <= divisor_zero;
                    rsp_divisor_norm  <= divisor_r << clz_out;
                    rsp_quotient_zero <= EARLY_OUT & ~divisor_zero & clz_gt;
                    rsp_iterations    <= (divisor_zero | clz_gt) ? 6'd0 : {1'b0, clz_out} - {1'b0, rsp_dividend_clz} + 6'd1;
                    rsp_valid         <= 1'b1;
                    state             <= DONE;
                end
                DONE: if (rsp_ack) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_normalize_sequencer.sv
// tb_div_normalize_sequencer: directed vectors against EARLY_OUT=1 and EARLY_OUT=0 instances
module tb_div_normalize_sequencer;
    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, rsp_ack = 1'b0;
    logic [31:0] req_dividend = '0, req_divisor = '0;
    logic [3:0]  req_id = '0;
    logic        req_ready, rsp_valid, rsp_divisor_zero, rsp_quotient_zero;
    logic [3:0]  rsp_id;
    logic [4:0]  rsp_dividend_clz, rsp_divisor_clz;
    logic [31:0] rsp_divisor_norm;
    logic [5:0]  rsp_iterations;
    logic        ne_req_ready, ne_rsp_valid, ne_divisor_zero, ne_quotient_zero;
    logic [3:0]  ne_id;
    logic [4:0]  ne_dividend_clz, ne_divisor_clz;
    logic [31:0] ne_divisor_norm;
    logic [5:0]  ne_iterations;
`ifdef DIV_NORMALIZE_SIGNED_EN
    logic req_signed = 1'b0, rsp_dividend_neg, rsp_divisor_neg, ne_dividend_neg, ne_divisor_neg;
`endif
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    div_normalize_sequencer #(.ID_WIDTH(4), .EARLY_OUT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .req_id(req_id),
`ifdef DIV_NORMALIZE_SIGNED_EN
        .req_signed(req_signed), .rsp_dividend_neg(rsp_dividend_neg), .rsp_divisor_neg(rsp_divisor_neg),
`endif
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_id(rsp_id),
        .rsp_dividend_clz(rsp_dividend_clz), .rsp_divisor_clz(rsp_divisor_clz),
        .rsp_divisor_norm(rsp_divisor_norm), .rsp_iterations(rsp_iterations),
        .rsp_divisor_zero(rsp_divisor_zero), .rsp_quotient_zero(rsp_quotient_zero)
    );
    div_normalize_sequencer #(.ID_WIDTH(4), .EARLY_OUT(1'b0)) u_dut_ne (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ne_req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .req_id(req_id),
`ifdef DIV_NORMALIZE_SIGNED_EN
        .req_signed(req_signed), .rsp_dividend_neg(ne_dividend_neg), .rsp_divisor_neg(ne_divisor_neg),
`endif
        .rsp_valid(ne_rsp_valid), .rsp_ack(rsp_ack), .rsp_id(ne_id),
        .rsp_dividend_clz(ne_dividend_clz), .rsp_divisor_clz(ne_divisor_clz),
        .rsp_divisor_norm(ne_divisor_norm), .rsp_iterations(ne_iterations),
        .rsp_divisor_zero(ne_divisor_zero), .rsp_quotient_zero(ne_quotient_zero)
    );
    typedef struct packed {
        logic [31:0] a, b;
        logic [3:0]  id;
        logic [4:0]  dclz, vclz;
        logic [31:0] norm;
        logic [5:0]  iter;
        logic        dz, qz;
        logic [5:0]  iter_ne;
    } vec_t;
    vec_t vecs [6] = '{
        '{32'd100,        32'd7,     4'h3, 5'd25, 5'd29, 32'hE000_0000, 6'd5,  1'b0, 1'b0, 6'd5},
        '{32'd5,          32'h100,   4'h5, 5'd29, 5'd23, 32'h8000_0000, 6'd0,  1'b0, 1'b1, 6'd0},
        '{32'h1234,       32'd0,     4'h6, 5'd19, 5'd31, 32'h0000_0000, 6'd0,  1'b1, 1'b0, 6'd0},
        '{32'hFFFF_FFFF,  32'd1,     4'h7, 5'd0,  5'd31, 32'h8000_0000, 6'd32, 1'b0, 1'b0, 6'd32},
        '{32'd1,          32'd1,     4'h8, 5'd31, 5'd31, 32'h8000_0000, 6'd1,  1'b0, 1'b0, 6'd1},
        '{32'd0,          32'd5,     4'h9, 5'd31, 5'd29, 32'hA000_0000, 6'd0,  1'b0, 1'b1, 6'd0}
    };
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] id);
        check("ready_before", req_ready, 1'b1);
        req_dividend = a; req_divisor = b; req_id = id; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_dividend = ~a; req_divisor = ~b; req_id = ~id;
        check("valid_c1", rsp_valid, 1'b0);
        @(posedge clk); #1;
        check("valid_c2", rsp_valid, 1'b0);
        check("ready_busy", req_ready, 1'b0);
        @(posedge clk); #1;
        check("valid_c3", rsp_valid, 1'b1);
        check("ne_valid_c3", ne_rsp_valid, 1'b1);
    endtask
    task automatic ack();
        rsp_ack = 1'b1;
        @(posedge clk); #1;
        rsp_ack = 1'b0;
        check("ready_after_ack", req_ready, 1'b1);
        check("valid_after_ack", rsp_valid, 1'b0);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_iter", rsp_iterations, 6'd0);
        check("rst_norm", rsp_divisor_norm, 32'd0);
        check("rst_clz", {rsp_dividend_clz, rsp_divisor_clz}, 10'd0);
        check("rst_flags", {rsp_divisor_zero, rsp_quotient_zero}, 2'b00);
        rst = 1'b0;
        req_dividend = 32'd50; req_divisor = 32'd3; req_id = 4'h1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", rsp_valid, 1'b0);
        check("midrst_ready", req_ready, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_rsp", rsp_valid, 1'b0);
        end
        rst = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b0;
        check("rst_valid_held_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        check("rst_valid_held_idle", req_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].id);
            check($sformatf("id%0d", i), rsp_id, vecs[i].id);
            check($sformatf("dclz%0d", i), rsp_dividend_clz, vecs[i].dclz);
            check($sformatf("vclz%0d", i), rsp_divisor_clz, vecs[i].vclz);
            check($sformatf("norm%0d", i), rsp_divisor_norm, vecs[i].norm);
            check($sformatf("iter%0d", i), rsp_iterations, vecs[i].iter);
            check($sformatf("dz%0d", i), rsp_divisor_zero, vecs[i].dz);
            check($sformatf("qz%0d", i), rsp_quotient_zero, vecs[i].qz);
            check($sformatf("ne_qz%0d", i), ne_quotient_zero, 1'b0);
            check($sformatf("ne_iter%0d", i), ne_iterations, vecs[i].iter_ne);
            if (i == 0) begin
                req_dividend = 32'd9; req_divisor = 32'd2; req_id = 4'hF; req_valid = 1'b1;
                repeat (10) begin
                    @(posedge clk); #1;
                    check("hold_valid", rsp_valid, 1'b1);
                    check("hold_ready", req_ready, 1'b0);
                    check("hold_iter", rsp_iterations, vecs[0].iter);
                    check("hold_id", rsp_id, vecs[0].id);
                end
                req_valid = 1'b0;
            end
            ack();
        end
`ifdef DIV_NORMALIZE_SIGNED_EN
        req_signed = 1'b1;
        issue(32'hFFFF_FF9C, 32'd7, 4'hA);
        check("s_dneg", rsp_dividend_neg, 1'b1);
        check("s_vneg", rsp_divisor_neg, 1'b0);
        check("s_dclz", rsp_dividend_clz, 5'd25);
        check("s_iter", rsp_iterations, 6'd5);
        ack();
        issue(32'h8000_0000, 32'd1, 4'hB);
        check("s_min_neg", rsp_dividend_neg, 1'b1);
        check("s_min_clz", rsp_dividend_clz, 5'd0);
        check("s_min_iter", rsp_iterations, 6'd32);
        ack();
        req_signed = 1'b0;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
